// File: rtl/riscv_id_pipe.sv
// riscv_id_pipe: RV32I decode into a valid/ready ID/EX register; RISCV_ID_HAZARD_EN enables the load-use interlock
module riscv_id_pipe #(
    parameter int XLEN          = 32,
    parameter int REGFILE_COUNT = 32,
    localparam int RA           = $clog2(REGFILE_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [RA-1:0]   rs1_o,
    output logic [RA-1:0]   rs2_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [RA-1:0]   rs1_idx_o,
    output logic [RA-1:0]   rs2_idx_o,
    output logic [RA-1:0]   rd_o,
    output logic            alu_src_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic [1:0]      alu_op_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            illegal_o
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0]      w_opc;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_alu_src, w_mem_to_reg, w_reg_write, w_mem_read;
    logic            w_mem_write, w_branch, w_jump, w_illegal;
    logic [1:0]      w_alu_op;
    logic            w_hazard, w_load_en;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_imm, r_rs1_data, r_rs2_data;
    logic [RA-1:0]   r_rs1_idx, r_rs2_idx, r_rd;
    logic            r_alu_src, r_mem_to_reg, r_reg_write, r_mem_read;
    logic            r_mem_write, r_branch, r_jump, r_illegal;
    logic [1:0]      r_alu_op;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;

    assign w_opc = instr_i[6:0];
    assign rs1_o = instr_i[15 +: RA];
    assign rs2_o = instr_i[20 +: RA];

    always_comb begin
        w_imm32 = '0;
        case (w_opc)
            OP_IMM, OP_LOAD, OP_JALR: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OP_STORE:                 w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OP_BRANCH:                w_imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         w_imm32 = {instr_i[31:12], 12'b0};
            OP_JAL:                   w_imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default:                  w_imm32 = '0;
        endcase
    end

    assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

    // Legal opcodes all end in 2'b11, so the default arm also covers instr[1:0] != 11.
    always_comb begin
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_alu_op     = 2'b00;
        w_illegal    = 1'b0;
        case (w_opc)
            OP_R:      begin w_reg_write = 1'b1; w_alu_op = 2'b10; end
            OP_IMM:    begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 2'b10; end
            OP_LOAD:   begin w_alu_src = 1'b1; w_mem_read = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1; end
            OP_STORE:  begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
            OP_BRANCH: begin w_branch = 1'b1; w_alu_op = 2'b01; end
            OP_JAL:    begin w_jump = 1'b1; w_reg_write = 1'b1; end
            OP_JALR:   begin w_jump = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1; end
            OP_LUI, OP_AUIPC: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

`ifdef RISCV_ID_HAZARD_EN
    logic w_uses_rs2;
    assign w_uses_rs2 = (w_opc == OP_R) | (w_opc == OP_STORE) | (w_opc == OP_BRANCH);
    assign w_hazard   = valid_i & r_valid & r_mem_read & (r_rd != '0)
                      & ((r_rd == rs1_o) | ((r_rd == rs2_o) & w_uses_rs2));
`else
    assign w_hazard = 1'b0;
`endif

    assign w_load_en = ready_i | ~r_valid;
    assign ready_o   = flush_i | (w_load_en & ~w_hazard);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_rs1_idx    <= '0;
            r_rs2_idx    <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_alu_op     <= 2'b00;
            r_funct3     <= 3'b000;
            r_funct7     <= 7'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (flush_i)
                r_valid <= 1'b0;
            else if (w_load_en)
                r_valid <= valid_i & ~w_hazard;
            if (w_load_en) begin
                r_pc         <= pc_i;
                r_imm        <= w_imm;
                r_rs1_data   <= rs1_data_i;
                r_rs2_data   <= rs2_data_i;
                r_rs1_idx    <= rs1_o;
                r_rs2_idx    <= rs2_o;
                r_rd         <= instr_i[7 +: RA];
                r_alu_src    <= w_alu_src;
                r_mem_to_reg <= w_mem_to_reg;
                r_reg_write  <= w_reg_write;
                r_mem_read   <= w_mem_read;
                r_mem_write  <= w_mem_write;
                r_branch     <= w_branch;
                r_jump       <= w_jump;
                r_alu_op     <= w_alu_op;
                r_funct3     <= instr_i[14:12];
                r_funct7     <= instr_i[31:25];
                r_illegal    <= w_illegal;
            end
        end
    end

    assign valid_o      = r_valid;
    assign pc_o         = r_pc;
    assign imm_o        = r_imm;
    assign rs1_data_o   = r_rs1_data;
    assign rs2_data_o   = r_rs2_data;
    assign rs1_idx_o    = r_rs1_idx;
    assign rs2_idx_o    = r_rs2_idx;
    assign rd_o         = r_rd;
    assign alu_src_o    = r_alu_src;
    assign mem_to_reg_o = r_mem_to_reg;
    assign reg_write_o  = r_reg_write;
    assign mem_read_o   = r_mem_read;
    assign mem_write_o  = r_mem_write;
    assign branch_o     = r_branch;
    assign jump_o       = r_jump;
    assign alu_op_o     = r_alu_op;
    assign funct3_o     = r_funct3;
    assign funct7_o     = r_funct7;
    assign illegal_o    = r_illegal;
endmodule

// File: tb/tb_riscv_id_pipe.sv
// tb_riscv_id_pipe: directed checks of decode, handshake, load-use, stall, flush and reset
module tb_riscv_id_pipe;
`ifdef RISCV_ID_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_i, flush_i;
    logic        ready_o, valid_o;
    logic [31:0] pc_i, instr_i, rs1_data_i, rs2_data_i;
    logic [4:0]  rs1_o, rs2_o, rs1_idx_o, rs2_idx_o, rd_o;
    logic [31:0] pc_o, imm_o, rs1_data_o, rs2_data_o;
    logic        alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o;
    logic [1:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign rs1_data_i = 32'h1000_0000 | 32'(rs1_o);
    assign rs2_data_i = 32'h2000_0000 | 32'(rs2_o);

    riscv_id_pipe dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .flush_i(flush_i),
        .pc_o(pc_o), .imm_o(imm_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o), .rd_o(rd_o),
        .alu_src_o(alu_src_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
        .jump_o(jump_o), .alu_op_o(alu_op_o), .funct3_o(funct3_o),
        .funct7_o(funct7_o), .illegal_o(illegal_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        valid_i = v;
        pc_i    = pc;
        instr_i = ins;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        pc_i = '0; instr_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_f3", funct3_o, 0);
        chk("rst_f7", funct7_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_regwr", reg_write_o, 0);
        chk("rst_rs1d", rs1_data_o, 0);
        chk("rst_ready", ready_o, 1);

        drive(1'b1, 32'h100, 32'hFE010113);
        tick();
        chk("addi_valid", valid_o, 1);
        chk("addi_imm", imm_o, 32'hFFFFFFE0);
        chk("addi_alusrc", alu_src_o, 1);
        chk("addi_regwr", reg_write_o, 1);
        chk("addi_aluop", alu_op_o, 2);
        chk("addi_rd", rd_o, 2);
        chk("addi_pc", pc_o, 32'h100);
        chk("addi_rs1d", rs1_data_o, 32'h1000_0002);

        drive(1'b1, 32'h104, 32'hFE5FF06F);
        tick();
        chk("jal_imm", imm_o, 32'hFFFFFFE4);
        chk("jal_jump", jump_o, 1);
        chk("jal_alusrc", alu_src_o, 0);

        drive(1'b1, 32'h108, 32'hFE20AE23);
        tick();
        chk("sw_imm", imm_o, 32'hFFFFFFFC);
        chk("sw_memwr", mem_write_o, 1);
        chk("sw_regwr", reg_write_o, 0);
        chk("sw_rs2d", rs2_data_o, 32'h2000_0002);

        drive(1'b1, 32'h10C, 32'hFE208CE3);
        tick();
        chk("beq_imm", imm_o, 32'hFFFFFFF8);
        chk("beq_branch", branch_o, 1);
        chk("beq_aluop", alu_op_o, 1);

        drive(1'b1, 32'h110, 32'h123451B7);
        tick();
        chk("lui_imm", imm_o, 32'h12345000);
        chk("lui_alusrc", alu_src_o, 1);
        chk("lui_aluop", alu_op_o, 0);

        drive(1'b1, 32'h114, 32'h0000A283);
        tick();
        chk("lw_memrd", mem_read_o, 1);
        chk("lw_memtoreg", mem_to_reg_o, 1);
        chk("lw_f3", funct3_o, 2);
        drive(1'b1, 32'h118, 32'h00228333);
        chk("lu_ready", ready_o, HZ ? 32'd0 : 32'd1);
        tick();
        chk("lu_valid", valid_o, HZ ? 32'd0 : 32'd1);
        chk("lu_ready2", ready_o, 1);
        if (HZ) tick();
        chk("add_valid", valid_o, 1);
        chk("add_rs1idx", rs1_idx_o, 5);
        chk("add_rs2idx", rs2_idx_o, 2);
        chk("add_rd", rd_o, 6);
        chk("add_rs1d", rs1_data_o, 32'h1000_0005);
        chk("add_memrd", mem_read_o, 0);

        ready_i = 1'b0;
        drive(1'b1, 32'h200, 32'h00500393);
        chk("stall_ready0", ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", valid_o, 1);
            chk("stall_rd", rd_o, 6);
            chk("stall_pc", pc_o, 32'h118);
            chk("stall_ready", ready_o, 0);
        end
        ready_i = 1'b1;
        #1;
        chk("unstall_ready", ready_o, 1);
        tick();
        chk("unstall_rd", rd_o, 7);
        chk("unstall_imm", imm_o, 5);
        chk("unstall_pc", pc_o, 32'h200);

        drive(1'b1, 32'h300, 32'h0000A283);
        tick();
        drive(1'b1, 32'h304, 32'h00228333);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", ready_o, 1);
        tick();
        flush_i = 1'b0;
        chk("flush_valid", valid_o, 0);
        drive(1'b0, 32'h0, 32'h0);
        chk("post_flush_ready", ready_o, 1);

        drive(1'b1, 32'h400, 32'h00000000);
        tick();
        chk("ill_valid", valid_o, 1);
        chk("ill_illegal", illegal_o, 1);
        chk("ill_regwr", reg_write_o, 0);
        chk("ill_memwr", mem_write_o, 0);
        chk("ill_memrd", mem_read_o, 0);
        chk("ill_branch", branch_o, 0);
        chk("ill_jump", jump_o, 0);

        ready_i = 1'b0;
        drive(1'b1, 32'h500, 32'hFE010113);
        tick();
        chk("stall_flush_pre", valid_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("stall_flush_valid", valid_o, 0);

        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        #1;
        chk("rst_stall_pre", valid_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("rst_stall_valid", valid_o, 0);
        chk("rst_stall_imm", imm_o, 0);
        chk("rst_stall_ready", ready_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
